tpu_sequencer: RTL and testbench
================================

TPU_SEQUENCER -- requirements
Module: tpu_sequencer

Interface
REQ-001 SHALL have parameter SIZE, default 8: systolic array dimension.
REQ-002 SHALL have parameter CW_ROWS, default 3: compensation-weight rows preloaded.
REQ-003 SHALL have parameter MEM_SIZE, default SIZE*SIZE: words per operand memory load.
REQ-004 SHALL have parameter CAL_CYCLES, default 3*SIZE: compute-phase length.
REQ-005 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-007 SHALL have port start  input  1  begin one tile job.
REQ-008 SHALL have port abort  input  1  cancel the job in progress.
REQ-009 SHALL have port load_valid  input  1  one weight/activation word written this cycle.
REQ-010 SHALL have port result_ready  input  1  consumer accepts the current result column.
REQ-011 SHALL have port load_mem_done  output  1  one-cycle pulse: memories full.
REQ-012 SHALL have port preload_cweight  output  1  compensation-weight preload enable.
REQ-013 SHALL have port preload_weight  output  1  reduced-weight preload enable.
REQ-014 SHALL have port cal  output  1  compute enable for array and accumulators.
REQ-015 SHALL have port result_valid  output  1  result column available.
REQ-016 SHALL have port result_col  output  $clog2(SIZE)  index of the presented column.
REQ-017 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-018 SHALL have port done  output  1  one-cycle pulse on job completion.
REQ-019 SHALL have port state  output  3  current FSM state encoding, for debug.

Function
REQ-020 FSM states SHALL be IDLE=0, LOAD=1, PRELOAD=2, CAL=3, OUT=4.
REQ-021 IDLE->LOAD SHALL occur on start=1; start SHALL be ignored in all other states.
REQ-022 LOAD SHALL count load_valid beats; load_valid SHALL be ignored outside LOAD.
REQ-023 On beat MEM_SIZE, LOAD->PRELOAD SHALL occur, with load_mem_done high for exactly the next cycle.
REQ-024 PRELOAD SHALL last exactly SIZE cycles with preload_weight=1 throughout.
REQ-025 preload_cweight SHALL be 1 only in the first CW_ROWS PRELOAD cycles.
REQ-026 CAL SHALL last exactly CAL_CYCLES cycles with cal=1; preload_* SHALL be 0 in CAL.
REQ-027 In OUT, result_valid SHALL be 1 and result_col SHALL start at 0.
REQ-028 In OUT, result_col SHALL increment on each cycle where result_valid and result_ready are both 1.
REQ-029 result_col SHALL hold while result_ready=0.
REQ-030 On the handshake at col SIZE-1, OUT->IDLE SHALL occur, with done=1 and result_valid=0 in the next cycle.
REQ-031 All outputs SHALL be registered and change one cycle after the causing edge; no combinational input-to-output path.
REQ-032 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, clear counters, and drop all enables; done SHALL NOT pulse.
REQ-033 abort SHALL take priority over simultaneous start, load_valid or a handshake.
REQ-034 The phase counter SHALL be $clog2(max(MEM_SIZE,CAL_CYCLES))+1 bits, zeroed on every state entry; it SHALL never wrap within a phase.
REQ-035 A start in the cycle done is high SHALL be accepted (IDLE at that edge).

Reset
REQ-036 With rst=0 at a clock edge, the block SHALL enter state IDLE with counters=0 and every output=0 (result_col=0, busy=0).
REQ-037 Reset mid-operation SHALL behave like abort and SHALL take priority over it.

Structure
REQ-038 Package tpu_pkg SHALL hold the state enum, default SIZE/CW_ROWS, and the CAL_CYCLES formula.
REQ-039 A single sub-module tpu_phase_cnt (load/clear/terminal-count compare) SHALL be used.
REQ-040 Target size is 150-300 lines of RTL.

Verification
REQ-041 Reset + start + 64 consecutive load_valid -> load_mem_done pulses 1 cycle; preload_weight high 8 cycles, preload_cweight first 3; cal high 24; then result_valid.
REQ-042 load_valid with gaps (every other cycle, 64 beats) -> load_mem_done only after beat 64; extra beats in PRELOAD have no effect.
REQ-043 result_ready held 0 for 5 cycles then 1 -> result_col stays 0, then steps 0..7; done pulses once; busy=0 afterward.
REQ-044 abort on CAL cycle 10 -> next cycle state=IDLE, cal=0, done=0; a new start completes a full job normally.
REQ-045 rst low during PRELOAD together with start -> all outputs 0 at IDLE; start ignored until rst high.
REQ-046 start asserted on the done cycle -> LOAD entered immediately, busy=1.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared types, defaults and sizing helpers for the TPU tile sequencer.
package tpu_pkg;

  localparam int DEFAULT_SIZE    = 8;
  localparam int DEFAULT_CW_ROWS = 3;

  // Encoding is visible on the debug state port, so the values are fixed.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PRELOAD = 3'd2,
    ST_CAL     = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  // The compute phase lasts three array widths: fill, steady state, drain.
  function automatic int cal_cycles(input int size);
    return 3 * size;
  endfunction

  // Phase counter width: one spare bit above the longest phase so it never wraps.
  function automatic int phase_cnt_width(input int mem_size, input int cal_len);
    int longest;
    longest = (mem_size > cal_len) ? mem_size : cal_len;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/tpu_phase_cnt.sv
// Phase counter: clear/increment with a terminal-count compare on the
// registered value. The next value is exported so the owner can register
// outputs that depend on the count without an extra cycle of latency.
module tpu_phase_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] tc,
  output logic [W-1:0] count_next,
  output logic         at_tc
);

  logic [W-1:0] count_q;

  // Next count: clear wins over increment.
  always_comb begin
    count_next = count_q;
    if (clr) begin
      count_next = '0;
    end else if (inc) begin
      count_next = count_q + W'(1);
    end
  end

  // Count register, zeroed by the active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  assign at_tc = (count_q == tc);

endmodule

// File: rtl/tpu_sequencer.sv
// Tile-job sequencer for the systolic array: LOAD operand memories,
// PRELOAD weights, CAL compute, then OUT result columns to a consumer.
//
// Result handshake: a column transfers on a rising edge where result_valid
// and result_ready are both 1. result_valid stays high and result_col stays
// stable until that transfer; result_valid never depends on result_ready.
//
// Every output is a flop loaded from next-state decode, so nothing passes
// combinationally from an input to an output.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int SIZE       = DEFAULT_SIZE,
  parameter int CW_ROWS    = DEFAULT_CW_ROWS,
  parameter int MEM_SIZE   = SIZE * SIZE,
  parameter int CAL_CYCLES = cal_cycles(SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic                    load_valid,
  input  logic                    result_ready,
  output logic                    load_mem_done,
  output logic                    preload_cweight,
  output logic                    preload_weight,
  output logic                    cal,
  output logic                    result_valid,
  output logic [$clog2(SIZE)-1:0] result_col,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              state
);

  localparam int CNT_W = phase_cnt_width(MEM_SIZE, CAL_CYCLES);
  localparam int COL_W = $clog2(SIZE);

  state_t             state_q, state_d;
  logic               cnt_clr, cnt_inc, cnt_at_tc;
  logic [CNT_W-1:0]   cnt_tc, cnt_next;
  logic               load_mem_done_d, done_d;
  logic               busy_d, preload_weight_d, preload_cweight_d, cal_d, result_valid_d;
  logic [COL_W-1:0]   result_col_d;

  tpu_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .clr        (cnt_clr),
    .inc        (cnt_inc),
    .tc         (cnt_tc),
    .count_next (cnt_next),
    .at_tc      (cnt_at_tc)
  );

  // Terminal count for the current phase (last beat/cycle index).
  always_comb begin
    cnt_tc = '0;
    case (state_q)
      ST_LOAD:    cnt_tc = CNT_W'(MEM_SIZE - 1);
      ST_PRELOAD: cnt_tc = CNT_W'(SIZE - 1);
      ST_CAL:     cnt_tc = CNT_W'(CAL_CYCLES - 1);
      ST_OUT:     cnt_tc = CNT_W'(SIZE - 1);
      default:    cnt_tc = '0;
    endcase
  end

  // Next state and counter control; abort overrides everything.
  always_comb begin
    state_d         = state_q;
    cnt_clr         = 1'b0;
    cnt_inc         = 1'b0;
    load_mem_done_d = 1'b0;
    done_d          = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          cnt_clr = 1'b1;
        end
      end
      ST_LOAD: begin
        if (load_valid) begin
          if (cnt_at_tc) begin
            state_d         = ST_PRELOAD;
            cnt_clr         = 1'b1;
            load_mem_done_d = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      ST_PRELOAD: begin
        if (cnt_at_tc) begin
          state_d = ST_CAL;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_CAL: begin
        if (cnt_at_tc) begin
          state_d = ST_OUT;
          cnt_clr = 1'b1;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_OUT: begin
        if (result_ready) begin
          if (cnt_at_tc) begin
            state_d = ST_IDLE;
            cnt_clr = 1'b1;
            done_d  = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    if (abort) begin
      state_d         = ST_IDLE;
      cnt_clr         = 1'b1;
      cnt_inc         = 1'b0;
      load_mem_done_d = 1'b0;
      done_d          = 1'b0;
    end
  end

  // Output decode from the state and count that will hold next cycle.
  always_comb begin
    busy_d            = (state_d != ST_IDLE);
    preload_weight_d  = (state_d == ST_PRELOAD);
    preload_cweight_d = (state_d == ST_PRELOAD) && (cnt_next < CNT_W'(CW_ROWS));
    cal_d             = (state_d == ST_CAL);
    result_valid_d    = (state_d == ST_OUT);
    result_col_d      = '0;
    if (state_d == ST_OUT) begin
      result_col_d = cnt_next[COL_W-1:0];
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      load_mem_done   <= 1'b0;
      preload_cweight <= 1'b0;
      preload_weight  <= 1'b0;
      cal             <= 1'b0;
      result_valid    <= 1'b0;
      result_col      <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state_q         <= state_d;
      load_mem_done   <= load_mem_done_d;
      preload_cweight <= preload_cweight_d;
      preload_weight  <= preload_weight_d;
      cal             <= cal_d;
      result_valid    <= result_valid_d;
      result_col      <= result_col_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: directed job scenarios followed by random
// input traffic, all checked cycle by cycle against a phase-level model.
module tb_tpu_sequencer;

  localparam int SIZE       = 8;
  localparam int CW_ROWS    = 3;
  localparam int MEM_SIZE   = SIZE * SIZE;
  localparam int CAL_CYCLES = 3 * SIZE;
  localparam int COL_W      = $clog2(SIZE);

  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_PRE = 2, PH_CAL = 3, PH_OUT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic start = 1'b0, abort = 1'b0, load_valid = 1'b0, result_ready = 1'b0;
  logic             load_mem_done, preload_cweight, preload_weight, cal;
  logic             result_valid, busy, done;
  logic [COL_W-1:0] result_col;
  logic [2:0]       state;

  tpu_sequencer #(
    .SIZE(SIZE), .CW_ROWS(CW_ROWS), .MEM_SIZE(MEM_SIZE), .CAL_CYCLES(CAL_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .load_valid(load_valid), .result_ready(result_ready),
    .load_mem_done(load_mem_done), .preload_cweight(preload_cweight),
    .preload_weight(preload_weight), .cal(cal), .result_valid(result_valid),
    .result_col(result_col), .busy(busy), .done(done), .state(state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase plus "how much of this phase is done" counts.
  int   m_phase = PH_IDLE;
  int   m_beats = 0, m_pre = 0, m_cal = 0, m_col = 0;
  logic e_lmd = 1'b0, e_done = 1'b0;
  logic [COL_W-1:0] exp_q[$];

  int c_lmd = 0, c_pw = 0, c_pcw = 0, c_cal = 0, c_done = 0, c_hs = 0;

  task automatic model_step();
    e_lmd  = 1'b0;
    e_done = 1'b0;
    if (!rst || abort) begin
      m_phase = PH_IDLE;
      m_beats = 0; m_pre = 0; m_cal = 0; m_col = 0;
      exp_q.delete();
    end else begin
      case (m_phase)
        PH_IDLE: if (start) begin m_phase = PH_LOAD; m_beats = 0; end
        PH_LOAD: if (load_valid) begin
          m_beats++;
          if (m_beats == MEM_SIZE) begin m_phase = PH_PRE; m_pre = 0; e_lmd = 1'b1; end
        end
        PH_PRE: begin
          m_pre++;
          if (m_pre == SIZE) begin m_phase = PH_CAL; m_cal = 0; end
        end
        PH_CAL: begin
          m_cal++;
          if (m_cal == CAL_CYCLES) begin
            m_phase = PH_OUT;
            m_col   = 0;
            for (int i = 0; i < SIZE; i++) exp_q.push_back(COL_W'(i));
          end
        end
        PH_OUT: if (result_ready) begin
          if (m_col == SIZE - 1) begin m_phase = PH_IDLE; e_done = 1'b1; end
          else m_col++;
        end
        default: m_phase = PH_IDLE;
      endcase
    end
  endtask

  // Monitor: scoreboard pops on transfers, model advances, outputs compared.
  always @(posedge clk) begin
    logic [COL_W-1:0] exp_col;
    if (rst && !abort && m_phase == PH_OUT && result_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_col = exp_q.pop_front();
        check("sb_col", 32'(result_col), 32'(exp_col));
        c_hs++;
      end
    end
    model_step();
    #1;
    check("state",   32'(state),           32'(m_phase));
    check("busy",    32'(busy),            32'(m_phase != PH_IDLE));
    check("lmd",     32'(load_mem_done),   32'(e_lmd));
    check("pw",      32'(preload_weight),  32'(m_phase == PH_PRE));
    check("pcw",     32'(preload_cweight), 32'(m_phase == PH_PRE && m_pre < CW_ROWS));
    check("cal",     32'(cal),             32'(m_phase == PH_CAL));
    check("rvalid",  32'(result_valid),    32'(m_phase == PH_OUT));
    check("rcol",    32'(result_col),      32'(m_phase == PH_OUT ? m_col : 0));
    check("done",    32'(done),            32'(e_done));
    if (load_mem_done)   c_lmd++;
    if (preload_weight)  c_pw++;
    if (preload_cweight) c_pcw++;
    if (cal)             c_cal++;
    if (done)            c_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    start = 1'b0; abort = 1'b0; load_valid = 1'b0; result_ready = 1'b0;
  endtask

  task automatic clear_counts();
    c_lmd = 0; c_pw = 0; c_pcw = 0; c_cal = 0; c_done = 0; c_hs = 0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    drive_idle();
    repeat (n) tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic load_beats(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1; tick(); load_valid = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_phase(input string tag, input int ph, input int budget);
    int k = 0;
    while (m_phase != ph && k < budget) begin tick(); k++; end
    if (m_phase != ph) check(tag, 32'(m_phase), 32'(ph));
  endtask

  task automatic job_counts(input string tag);
    check({tag, "_lmd_cnt"},  32'(c_lmd),  32'd1);
    check({tag, "_pw_cnt"},   32'(c_pw),   32'(SIZE));
    check({tag, "_pcw_cnt"},  32'(c_pcw),  32'(CW_ROWS));
    check({tag, "_cal_cnt"},  32'(c_cal),  32'(CAL_CYCLES));
    check({tag, "_done_cnt"}, 32'(c_done), 32'd1);
    check({tag, "_hs_cnt"},   32'(c_hs),   32'(SIZE));
    check({tag, "_busy_end"}, 32'(busy),   32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    do_reset(3);
    check("rst_state", 32'(state), 32'd0);
    check("rst_busy",  32'(busy),  32'd0);

    // Back-to-back load, consumer always ready.
    clear_counts();
    pulse_start();
    load_beats(MEM_SIZE, 0);
    result_ready = 1'b1;
    wait_phase("j1_wait_idle", PH_IDLE, 200);
    result_ready = 1'b0;
    tick();
    job_counts("j1");

    // Gapped load; extra beats during PRELOAD must be ignored.
    clear_counts();
    pulse_start();
    load_beats(MEM_SIZE - 1, 1);
    check("j2_lmd_early", 32'(c_lmd), 32'd0);
    load_beats(1, 0);
    load_valid = 1'b1; repeat (5) tick(); load_valid = 1'b0;
    result_ready = 1'b1;
    wait_phase("j2_wait_idle", PH_IDLE, 200);
    result_ready = 1'b0;
    tick();
    job_counts("j2");

    // Consumer stalls 5 cycles at the start of OUT.
    clear_counts();
    pulse_start();
    load_beats(MEM_SIZE, 0);
    wait_phase("j3_wait_out", PH_OUT, 100);
    repeat (5) tick();
    check("j3_col_hold", 32'(result_col), 32'd0);
    result_ready = 1'b1;
    wait_phase("j3_wait_idle", PH_IDLE, 50);
    result_ready = 1'b0;
    tick();
    job_counts("j3");

    // Abort in the tenth CAL cycle, then a clean job.
    pulse_start();
    load_beats(MEM_SIZE, 0);
    k = 0;
    while (!(m_phase == PH_CAL && m_cal == 9) && k < 100) begin tick(); k++; end
    check("j4_reach_cal10", 32'(m_cal), 32'd9);
    abort = 1'b1; tick(); abort = 1'b0;
    check("j4_abort_state", 32'(state), 32'd0);
    check("j4_abort_cal",   32'(cal),   32'd0);
    check("j4_abort_done",  32'(done),  32'd0);
    clear_counts();
    pulse_start();
    load_beats(MEM_SIZE, 0);
    result_ready = 1'b1;
    wait_phase("j4_wait_idle", PH_IDLE, 200);
    result_ready = 1'b0;
    tick();
    job_counts("j4");

    // Reset during PRELOAD with start held.
    pulse_start();
    load_beats(MEM_SIZE, 0);
    tick();
    rst = 1'b0; start = 1'b1;
    tick();
    check("j5_rst_state", 32'(state),          32'd0);
    check("j5_rst_busy",  32'(busy),           32'd0);
    check("j5_rst_pw",    32'(preload_weight), 32'd0);
    check("j5_rst_pcw",   32'(preload_cweight),32'd0);
    repeat (2) tick();
    check("j5_rst_hold",  32'(state),          32'd0);
    rst = 1'b1; start = 1'b0;
    tick();
    check("j5_after_rst", 32'(state), 32'd0);

    // Start on the done cycle.
    pulse_start();
    load_beats(MEM_SIZE, 0);
    result_ready = 1'b1;
    k = 0;
    while (!e_done && k < 200) begin tick(); k++; end
    check("j6_done_seen", 32'(done), 32'd1);
    result_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check("j6_state_load", 32'(state), 32'(PH_LOAD));
    check("j6_busy",       32'(busy),  32'd1);
    abort = 1'b1; tick(); abort = 1'b0;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      rst          = ($urandom_range(0, 1999) != 0);
      start        = ($urandom_range(0, 9) == 0);
      abort        = ($urandom_range(0, 599) == 0);
      load_valid   = ($urandom_range(0, 9) < 7);
      result_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    rst = 1'b1;
    drive_idle();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
